// File: rtl/fifo_pkg.sv
// Shared defaults and size derivations for the parametrised FIFO and its RAM.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH = 3;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram_param.sv
// Simple dual-port RAM: synchronous write port, registered read port.
module fifo_dpram_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The output register holds its value between reads, so it doubles as data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and
// sticky overflow/underflow errors.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = cnt_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  umbral_superior,
  input  logic [CNT_WIDTH-1:0]  umbral_inferior,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(depth_of(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  th_hi_reg;
  logic [CNT_WIDTH-1:0]  th_lo_reg;
  logic                  valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic pop_ok;
  logic push_ok;

  // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
  assign pop_ok  = pop & (count_reg != '0);
  assign push_ok = push & ((count_reg != DEPTH_CNT) | pop_ok);

  fifo_dpram_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok & ~reset),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .re    (pop_ok & ~reset),
    .raddr (rd_ptr_reg),
    .rdata (data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      th_hi_reg     <= umbral_superior;
      th_lo_reg     <= umbral_inferior;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      end
      valid_reg <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_WIDTH'(1);
        2'b01:   count_reg <= count_reg - CNT_WIDTH'(1);
        default: count_reg <= count_reg;
      endcase
      if (push & ~push_ok) begin
        overflow_reg <= 1'b1;
      end
      if (pop & ~pop_ok) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  // Flags decode the count register; while reset is held they show the empty state.
  always_comb begin
    full         = ~reset & (count_reg == DEPTH_CNT);
    empty        = reset | (count_reg == '0);
    almost_full  = ~reset & (count_reg >= th_hi_reg);
    almost_empty = reset | (count_reg <= th_lo_reg);
  end

  assign count     = count_reg;
  assign valid_out = valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_param;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int CW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] umbral_superior = 4'd6;
  logic [CW-1:0] umbral_inferior = 4'd2;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_hi = 0;
  int            m_lo = 0;
  logic [DW-1:0] m_dout = '0;
  bit            m_vld = 0;
  bit            m_ovf = 0;
  bit            m_unf = 0;

  fifo_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .data_in         (data_in),
    .umbral_superior (umbral_superior),
    .umbral_inferior (umbral_inferior),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the model by the same transaction, sample 1 time unit after the edge.
  task automatic do_cycle(input bit r, input bit p, input bit q, input logic [DW-1:0] d);
    bit pok;
    bit wok;
    @(negedge clk);
    reset   = r;
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_vld  = 0;
      m_ovf  = 0;
      m_unf  = 0;
      m_hi   = int'(umbral_superior);
      m_lo   = int'(umbral_inferior);
    end else begin
      pok = q && (mq.size() > 0);
      wok = p && ((mq.size() < DEPTH) || pok);
      if (pok) begin
        m_dout = mq.pop_front();
        m_vld  = 1;
      end else begin
        m_vld = 0;
      end
      if (wok) mq.push_back(d);
      if (p && !wok) m_ovf = 1;
      if (q && !pok) m_unf = 1;
    end
    #1;
    $display("t=%0t rst=%0b push=%0b pop=%0b din=%03h -> cnt=%0d dout=%03h vld=%0b f=%0b e=%0b af=%0b ae=%0b ov=%0b un=%0b",
             $time, r, p, q, d, count, data_out, valid_out, full, empty,
             almost_full, almost_empty, overflow, underflow);
  endtask

  task automatic test_reset();
    umbral_superior = 4'd6;
    umbral_inferior = 4'd2;
    do_cycle(1, 0, 0, '0);
    do_cycle(1, 0, 0, '0);
    do_cycle(0, 0, 0, '0);
    total += 7;
    if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%0b exp=1", almost_empty); end
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
    if (data_out !== '0) begin bad++; $display("FAIL reset_dout got=%03h exp=000", data_out); end
    umbral_superior = 4'd1;
    umbral_inferior = 4'd1;
    do_cycle(0, 0, 0, '0);
    total += 2;
    if (almost_empty !== 1'b1) begin bad++; $display("FAIL idle_ae got=%0b exp=1", almost_empty); end
    if (almost_full !== 1'b0) begin bad++; $display("FAIL idle_af got=%0b exp=0", almost_full); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(0, 1, 0, DW'(i));
      total += 4;
      if (count !== CW'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      if (almost_empty !== (i <= 2)) begin bad++; $display("FAIL fill_ae[%0d] got=%0b exp=%0b", i, almost_empty, (i <= 2)); end
      if (almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, almost_full, (i >= 6)); end
      if (full !== (i == DEPTH)) begin bad++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i == DEPTH)); end
    end
    do_cycle(0, 1, 0, 10'h3FF);
    total += 3;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%0b exp=1", overflow); end
    if (count !== 4'd8) begin bad++; $display("FAIL fill_ovf_count got=%0d exp=8", count); end
    if (underflow !== 1'b0) begin bad++; $display("FAIL fill_underflow got=%0b exp=0", underflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(0, 0, 1, '0);
      total += 3;
      if (data_out !== DW'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%03h exp=%03h", i, data_out, i); end
      if (valid_out !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, valid_out); end
      if (count !== CW'(DEPTH - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, DEPTH - i); end
    end
    total += 1;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    do_cycle(0, 0, 1, '0);
    total += 3;
    if (underflow !== 1'b1) begin bad++; $display("FAIL drain_underflow got=%0b exp=1", underflow); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL drain_unf_valid got=%0b exp=0", valid_out); end
    if (data_out !== 10'h008) begin bad++; $display("FAIL drain_hold got=%03h exp=008", data_out); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] words [5];
    for (int i = 0; i < 5; i++) begin
      words[i] = DW'($urandom);
      do_cycle(0, 1, 0, words[i]);
    end
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 0, 1, '0);
      total += 1;
      if (data_out !== words[i]) begin bad++; $display("FAIL wrap_pre[%0d] got=%03h exp=%03h", i, data_out, words[i]); end
    end
    for (int i = 0; i < 6; i++) do_cycle(0, 1, 0, DW'(10'h3AA + i));
    total += 1;
    if (count !== 4'd6) begin bad++; $display("FAIL wrap_count got=%0d exp=6", count); end
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, 0, 1, '0);
      total += 2;
      if (data_out !== DW'(10'h3AA + i)) begin bad++; $display("FAIL wrap_data[%0d] got=%03h exp=%03h", i, data_out, 10'h3AA + i); end
      if (valid_out !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d] got=%0b exp=1", i, valid_out); end
    end
  endtask

  task automatic test_back_to_back();
    umbral_superior = 4'd6;
    umbral_inferior = 4'd2;
    do_cycle(1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 1, 0, DW'(10'h100 + i));
    do_cycle(0, 1, 1, 10'h2FF);
    total += 4;
    if (count !== 4'd8) begin bad++; $display("FAIL b2b_full_count got=%0d exp=8", count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_full_ovf got=%0b exp=0", overflow); end
    if (valid_out !== 1'b1) begin bad++; $display("FAIL b2b_full_valid got=%0b exp=1", valid_out); end
    if (data_out !== 10'h100) begin bad++; $display("FAIL b2b_full_data got=%03h exp=100", data_out); end
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(0, 0, 1, '0);
      total += 1;
      if (data_out !== ((i == DEPTH) ? 10'h2FF : DW'(10'h100 + i))) begin
        bad++;
        $display("FAIL b2b_drain[%0d] got=%03h exp=%03h", i, data_out, (i == DEPTH) ? 10'h2FF : 10'h100 + i);
      end
    end
    do_cycle(0, 1, 1, 10'h0AB);
    total += 4;
    if (count !== 4'd1) begin bad++; $display("FAIL b2b_empty_count got=%0d exp=1", count); end
    if (underflow !== 1'b1) begin bad++; $display("FAIL b2b_empty_unf got=%0b exp=1", underflow); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_empty_valid got=%0b exp=0", valid_out); end
    if (data_out !== 10'h2FF) begin bad++; $display("FAIL b2b_empty_hold got=%03h exp=2ff", data_out); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, DW'(10'h050 + i));
    total += 1;
    if (count !== 4'd4) begin bad++; $display("FAIL mid_pre_count got=%0d exp=4", count); end
    umbral_superior = 4'd2;
    umbral_inferior = 4'd0;
    do_cycle(1, 0, 0, '0);
    umbral_superior = 4'd7;
    umbral_inferior = 4'd7;
    do_cycle(0, 0, 0, '0);
    total += 5;
    if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%0b exp=1", empty); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", valid_out); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%0b exp=0", overflow); end
    if (underflow !== 1'b0) begin bad++; $display("FAIL mid_unf got=%0b exp=0", underflow); end
    do_cycle(0, 1, 0, 10'h155);
    total += 2;
    if (almost_empty !== 1'b0) begin bad++; $display("FAIL mid_ae got=%0b exp=0", almost_empty); end
    if (almost_full !== 1'b0) begin bad++; $display("FAIL mid_af1 got=%0b exp=0", almost_full); end
    do_cycle(0, 1, 0, 10'h0F0);
    total += 1;
    if (almost_full !== 1'b1) begin bad++; $display("FAIL mid_af2 got=%0b exp=1", almost_full); end
    do_cycle(0, 0, 1, '0);
    total += 2;
    if (data_out !== 10'h155) begin bad++; $display("FAIL mid_data got=%03h exp=155", data_out); end
    if (valid_out !== 1'b1) begin bad++; $display("FAIL mid_data_valid got=%0b exp=1", valid_out); end
  endtask

  task automatic test_random();
    bit r;
    bit p;
    bit q;
    int cnt;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 50);
      if (r) begin
        umbral_superior = CW'($urandom_range(0, DEPTH));
        umbral_inferior = CW'($urandom_range(0, DEPTH));
      end
      do_cycle(r, p, q, DW'($urandom));
      cnt = mq.size();
      total += 9;
      if (count !== CW'(cnt)) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, count, cnt); end
      if (data_out !== m_dout) begin bad++; $display("FAIL rnd_data[%0d] got=%03h exp=%03h", n, data_out, m_dout); end
      if (valid_out !== m_vld) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, valid_out, m_vld); end
      if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%0b exp=%0b", n, overflow, m_ovf); end
      if (underflow !== m_unf) begin bad++; $display("FAIL rnd_unf[%0d] got=%0b exp=%0b", n, underflow, m_unf); end
      if (full !== (!r && cnt == DEPTH)) begin bad++; $display("FAIL rnd_full[%0d] got=%0b exp=%0b", n, full, (!r && cnt == DEPTH)); end
      if (empty !== (r || cnt == 0)) begin bad++; $display("FAIL rnd_empty[%0d] got=%0b exp=%0b", n, empty, (r || cnt == 0)); end
      if (almost_full !== (!r && cnt >= m_hi)) begin bad++; $display("FAIL rnd_af[%0d] got=%0b exp=%0b", n, almost_full, (!r && cnt >= m_hi)); end
      if (almost_empty !== (r || cnt <= m_lo)) begin bad++; $display("FAIL rnd_ae[%0d] got=%0b exp=%0b", n, almost_empty, (r || cnt <= m_lo)); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the transaction-layer 8x10 FIFO. It generalises data width and depth, adds full/empty flags, an occupancy count, a read-valid strobe and sticky overflow/underflow errors. It defines the behaviour for simultaneous push/pop at every boundary. It sits between transaction-layer stages (VC/type buffers) and is driven by the TL state machine through reset and the threshold inputs.

Parameters:
DATA_WIDTH, 10, width of data_in/data_out
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (power of 2 only)
CNT_WIDTH, ADDR_WIDTH+1, width of count and thresholds (holds 0..DEPTH)

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
push  input  1  write request
pop  input  1  read request
data_in  input  DATA_WIDTH  write data
umbral_superior  input  CNT_WIDTH  almost-full threshold, captured during reset
umbral_inferior  input  CNT_WIDTH  almost-empty threshold, captured during reset
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  data_out holds a newly popped word this cycle
count  output  CNT_WIDTH  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= captured umbral_superior
almost_empty  output  1  count <= captured umbral_inferior
overflow  output  1  sticky: push attempted while not accepted
underflow  output  1  sticky: pop attempted while not accepted

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- While reset = 1, each cycle:
  - wr_ptr, rd_ptr and count go to 0.
  - data_out = 0; valid_out, overflow and underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - umbral_superior/umbral_inferior are latched into th_hi/th_lo. Thresholds are frozen outside reset.
  - Reset mid-operation discards all contents. The first cycle after reset deasserts is a normal operating cycle.
- Acceptance, evaluated on registered state at the clock edge:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). Push while full is accepted only if a pop is accepted in the same cycle.
- Write path: on push_ok, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1. ADDR_WIDTH-bit natural wrap, DEPTH-1 -> 0.
- Read path: on pop_ok, data_out <= mem[rd_ptr], rd_ptr <= rd_ptr+1 (natural wrap), valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its last value.
  - Read latency: one cycle from pop sample to data_out/valid_out.
- Count update:
  - push_ok only: count + 1.
  - pop_ok only: count - 1.
  - both or neither: unchanged.
  - count never leaves 0..DEPTH.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the count register and th_hi/th_lo, so they change on the same edge as count.
  - Outside reset, almost_empty can be 1 with threshold 0 only when empty; almost_full with threshold 0 is always 1. Both are legal configurations.
- Boundaries:
  - Empty + push + pop: push accepted, pop rejected, underflow set. count becomes 1 and valid_out = 0.
  - Full + push + pop: both accepted, count stays DEPTH, and the oldest word is output.
  - Full + push only: write dropped, memory and pointers unchanged, overflow set.
  - Empty + pop only: no pointer move, valid_out = 0, underflow set.
  - overflow and underflow stay 1 until reset.
- No read-during-write bypass is needed. A word written at cycle N is poppable from cycle N+1, because empty is derived from registered count.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH (10) and ADDR_WIDTH (3);
  - the function/constant for DEPTH = 2**ADDR_WIDTH;
  - the CNT_WIDTH derivation.
- One sub-module, fifo_dpram_param, is natural: a parametrised simple dual-port RAM with a synchronous write port (we, waddr, wdata) and a registered read port (re, raddr, rdata). It replaces the fixed 8x10 true_dpram_sclk.
- fifo_param keeps pointers, count, flags and error logic. The rdata register in fifo_dpram_param provides data_out; valid_out is a separate flop in fifo_param.

Test Plan:
Defaults, th_hi=6, th_lo=2 held during reset.
- Reset, then idle: count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid_out=0. Change the thresholds to 1/1 after reset: flags unaffected.
- Push 0x001..0x008 on 8 consecutive cycles:
  - count steps 1..8;
  - almost_empty drops when count=3;
  - almost_full rises when count=6;
  - full=1 after the 8th push.
  - Then a 9th push: overflow=1 and count stays 8.
- From full, pop 8 cycles: data_out = 0x001..0x008, each one cycle after its pop with valid_out=1. Then empty=1, and a 9th pop sets underflow=1 with valid_out=0.
- Wrap: push 5, pop 5, then push 0x3AA..0x3AF (6 words) so wr_ptr wraps past 7. Popping all 6 returns them in order.
- Simultaneous push+pop:
  - at full: count stays 8, no overflow, oldest word out;
  - at empty: count becomes 1, underflow=1, valid_out=0.
- Reset mid-stream with count=4: next cycle count=0, empty=1, valid_out=0, overflow and underflow cleared, new thresholds latched. Pushing 0x155 then popping returns 0x155.
